// File: rtl/golden_nonce_queue.sv
// Golden-nonce FIFO feeding serial_transmit one word per send/busy handshake.
// Optional duplicate suppression is enabled by defining CONFIG_NONCE_DEDUP_EN.
module golden_nonce_queue #(
    parameter int          DEPTH        = 16,
    parameter int          ADDR_W       = 4,
    parameter logic [31:0] NONCE_OFFSET = 32'd0,
    parameter logic [2:0]  BUSY_WAIT    = 3'd4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       nonce_in,
    input  logic              nonce_valid,
    input  logic              tx_busy,
    output logic              tx_send,
    output logic [31:0]       tx_word,
    output logic [ADDR_W:0]   fifo_count,
    output logic              empty,
    output logic [7:0]        overflow_cnt
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_BUSY = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic [1:0]        state;
    logic [2:0]        wait_cnt;
    logic [31:0]       adj;
    logic              pop, push, drop, dup;

    assign adj = nonce_in - NONCE_OFFSET;
    assign pop = (state == IDLE) && (count != '0) && !tx_busy;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign push = nonce_valid && !dup && ((count < FULL) || pop);
    assign drop = nonce_valid && !dup && !push;

`ifdef CONFIG_NONCE_DEDUP_EN
    logic [31:0] last_adj;
    logic        last_vld;

    assign dup = nonce_valid && last_vld && (adj == last_adj);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_adj <= '0;
            last_vld <= 1'b0;
        end else if (push) begin
            last_adj <= adj;
            last_vld <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= adj;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_cnt <= '0;
            state        <= IDLE;
            wait_cnt     <= '0;
            tx_send      <= 1'b0;
            tx_word      <= '0;
        end else begin
            tx_send <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_send  <= 1'b1;
                        tx_word  <= mem[rd_ptr];
                        wait_cnt <= '0;
                        state    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    // A word whose busy never rises is considered sent; no retry.
                    if (tx_busy)                             state <= WAIT_DONE;
                    else if (wait_cnt == BUSY_WAIT - 3'd1)   state <= IDLE;
                    else                                     wait_cnt <= wait_cnt + 1'b1;
                end
                WAIT_DONE: begin
                    if (!tx_busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fifo_count = count;
    assign empty      = (count == '0);
endmodule

// File: tb/tb_golden_nonce_queue.sv
// Bench for golden_nonce_queue: vector table, directed corner sequences and a
// random phase, all checked against a queue-based reference model.
module tb_golden_nonce_queue;
    localparam int          DEPTH = 16;
    localparam logic [31:0] OFF   = 32'd2;
    localparam int          BW    = 4;
`ifdef CONFIG_NONCE_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] nonce_in;
    logic        nonce_valid;
    logic        tx_busy;
    logic        tx_send;
    logic [31:0] tx_word;
    logic [4:0]  fifo_count;
    logic        empty;
    logic [7:0]  overflow_cnt;

    always #5 clk = ~clk;

    golden_nonce_queue #(.DEPTH(16), .ADDR_W(4), .NONCE_OFFSET(OFF), .BUSY_WAIT(3'd4)) dut (
        .clk(clk), .reset(reset), .nonce_in(nonce_in), .nonce_valid(nonce_valid),
        .tx_busy(tx_busy), .tx_send(tx_send), .tx_word(tx_word),
        .fifo_count(fifo_count), .empty(empty), .overflow_cnt(overflow_cnt)
    );

    int n_chk = 0;
    int n_fail = 0;

    // reference model: queue of pending words plus transmitter phase
    logic [31:0] mq[$];
    bit          m_send;
    logic [31:0] m_word;
    logic [7:0]  m_ovf;
    int          ph, tmr;
    logic [31:0] m_last;
    bit          m_lv;

    logic [31:0] sent[$];
    int          busy_left, ulen, peak;

    typedef struct {
        bit          v;
        logic [31:0] n;
        bit          b;
        bit          e_send;
        logic [31:0] e_word;
        int          e_cnt;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_send = 0; m_word = '0; m_ovf = '0; ph = 0; tmr = 0; m_lv = 0; m_last = '0;
    endtask

    task automatic model_step(input bit v, input logic [31:0] n, input bit b);
        logic [31:0] a;
        bit dup, snd;
        a   = n - OFF;
        dup = DEDUP && v && m_lv && (a == m_last);
        snd = (ph == 0) && (mq.size() > 0) && !b;
        m_send = snd;
        if (snd) begin
            m_word = mq.pop_front();
            ph = 1; tmr = 0;
        end else if (ph == 1) begin
            if (b) ph = 2;
            else if (tmr == BW - 1) ph = 0;
            else tmr++;
        end else if (ph == 2 && !b) ph = 0;
        if (v && !dup) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(a); m_last = a; m_lv = 1;
            end else if (m_ovf != 8'hFF) m_ovf++;
        end
    endtask

    task automatic cycle(input bit v, input logic [31:0] n, input bit b);
        nonce_valid = v; nonce_in = n; tx_busy = b;
        model_step(v, n, b);
        @(posedge clk);
        @(negedge clk);
        if (tx_send) sent.push_back(tx_word);
        chk("send",  {31'd0, tx_send}, {31'd0, m_send});
        chk("word",  tx_word, m_word);
        chk("count", {27'd0, fifo_count}, mq.size());
        chk("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
        chk("ovf",   {24'd0, overflow_cnt}, {24'd0, m_ovf});
    endtask

    // drives tx_busy like a UART that stays busy ulen cycles after each send
    task automatic ucycle(input bit v, input logic [31:0] n);
        bit b;
        b = (busy_left > 0);
        cycle(v, n, b);
        if (busy_left > 0) busy_left--;
        if (tx_send) busy_left = ulen;
        if (fifo_count > peak) peak = fifo_count;
    endtask

    task automatic settle(input int k);
        repeat (k) cycle(0, '0, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_send"},  {31'd0, tx_send}, 32'd0);
        chk({tag, "_word"},  tx_word, 32'd0);
        chk({tag, "_count"}, {27'd0, fifo_count}, 32'd0);
        chk({tag, "_empty"}, {31'd0, empty}, 32'd1);
        chk({tag, "_ovf"},   {24'd0, overflow_cnt}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want test end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_d[$];
        //           v  n             b  send word          cnt
        tbl[0] = '{1, 32'h00000105, 0, 0, 32'h0,         1};
        tbl[1] = '{0, 32'h0,        0, 1, 32'h00000103,  0};
        tbl[2] = '{0, 32'h0,        0, 0, 32'h00000103,  0};
        tbl[3] = '{0, 32'h0,        1, 0, 32'h00000103,  0};
        tbl[4] = '{0, 32'h0,        1, 0, 32'h00000103,  0};
        tbl[5] = '{0, 32'h0,        0, 0, 32'h00000103,  0};
        tbl[6] = '{1, 32'h00000001, 0, 0, 32'h00000103,  1};
        tbl[7] = '{0, 32'h0,        0, 1, 32'hFFFFFFFF,  0};
        tbl[8] = '{0, 32'h0,        0, 0, 32'hFFFFFFFF,  0};

        reset = 1'b1; nonce_valid = 0; nonce_in = '0; tx_busy = 0;
        busy_left = 0; ulen = 0; peak = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;

        // single nonce latency, single pulse, and adjust wrap
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].v, tbl[i].n, tbl[i].b);
            chk($sformatf("tbl%0d_send", i), {31'd0, tx_send}, {31'd0, tbl[i].e_send});
            chk($sformatf("tbl%0d_word", i), tx_word, tbl[i].e_word);
            chk($sformatf("tbl%0d_cnt", i), {27'd0, fifo_count}, tbl[i].e_cnt);
        end
        settle(8);

        // burst of 5 with a slow UART
        sent.delete(); busy_left = 0; ulen = 40; peak = 0;
        for (int i = 1; i <= 5; i++) ucycle(1, i + OFF);
        repeat (260) ucycle(0, '0);
        chk("burst_n", sent.size(), 32'd5);
        for (int i = 0; i < 5 && i < sent.size(); i++)
            chk($sformatf("burst_w%0d", i), sent[i], i + 1);
        chk("burst_peak", {31'd0, (peak == 4 || peak == 5)}, 32'd1);
        settle(8);

        // overflow with UART stuck busy, then full push+pop, then saturation
        for (int i = 0; i < 20; i++) cycle(1, 32'h100 + i, 1);
        chk("ovf_count", {27'd0, fifo_count}, 32'd16);
        chk("ovf_cnt4", {24'd0, overflow_cnt}, 32'd4);
        sent.delete();
        cycle(1, 32'hABC, 0);
        chk("full_pp_send", {31'd0, tx_send}, 32'd1);
        chk("full_pp_count", {27'd0, fifo_count}, 32'd16);
        chk("full_pp_ovf", {24'd0, overflow_cnt}, 32'd4);
        for (int i = 0; i < 300; i++) cycle(1, 32'h1000 + i, 1);
        chk("ovf_sat", {24'd0, overflow_cnt}, 32'hFF);
        busy_left = 0; ulen = 3;
        repeat (400) ucycle(0, '0);
        chk("drain_n", sent.size(), 32'd17);
        for (int i = 0; i < 17 && i < sent.size(); i++)
            chk($sformatf("drain_w%0d", i), sent[i], (i < 16) ? 32'hFE + i : 32'hABA);
        settle(8);

        // reset while waiting for the UART with 3 words queued
        busy_left = 0; ulen = 30;
        ucycle(1, 32'h500); ucycle(1, 32'h501); ucycle(1, 32'h502); ucycle(1, 32'h503);
        ucycle(0, '0); ucycle(0, '0);
        chk("pre_rst_count", {27'd0, fifo_count}, 32'd3);
        #2 reset = 1'b1;
        #1 chk_reset_vals("async_rst");
        model_reset(); busy_left = 0;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        sent.delete();
        settle(20);
        chk("post_rst_quiet", sent.size(), 32'd0);
        cycle(1, 32'h600, 0); settle(2);
        chk("post_rst_n", sent.size(), 32'd1);
        if (sent.size() > 0) chk("post_rst_w", sent[0], 32'h5FE);
        settle(8);

        // duplicate suppression sequence A,A,B,A
        sent.delete(); busy_left = 0; ulen = 2;
        ucycle(1, 32'h700); ucycle(1, 32'h700); ucycle(1, 32'h800); ucycle(1, 32'h700);
        repeat (60) ucycle(0, '0);
        if (DEDUP) exp_d = '{32'h6FE, 32'h7FE, 32'h6FE};
        else       exp_d = '{32'h6FE, 32'h6FE, 32'h7FE, 32'h6FE};
        chk("dedup_n", sent.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < sent.size(); i++)
            chk($sformatf("dedup_w%0d", i), sent[i], exp_d[i]);

        // random traffic: light busy, heavy busy, UART-like busy
        busy_left = 0; ulen = 5;
        for (int i = 0; i < 3000; i++) begin
            bit v, b;
            logic [31:0] n;
            v = ($urandom % 2) == 0;
            n = ($urandom % 4 == 0) ? $urandom : ($urandom % 4);
            if (i < 1000) begin
                b = ($urandom % 4) == 0;
                cycle(v, n, b);
            end else if (i < 2000) begin
                b = ($urandom % 8) != 0;
                cycle(v, n, b);
            end else begin
                ulen = $urandom_range(1, 8);
                ucycle(v, n);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
